// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and constants for the pipeline hazard unit.
//   FWD_*      : forwarding-mux select encodings for D/E operands.
//   FWD_M_*    : DM write-data select encodings for the M stage.
//   TUSE_*     : cycles until an operand is consumed, counted from D.
//   TNEW_*     : cycles until a result is produced, counted from E entry.
//   REG_ZERO   : index of $0, which never participates in a hazard.
package hazard_pkg;

  localparam logic [1:0] FWD_GPR = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_E   = 2'b11;

  localparam logic FWD_M_PIPE = 1'b0;
  localparam logic FWD_M_W    = 1'b1;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  localparam logic [1:0] TNEW_0   = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_LD  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_pipe_track.sv
// hazard_pipe_track: destination/Tnew shadow of the E, M and W stages.
//   clk_i, rst_ni    : clock, synchronous active-low reset.
//   stall_i          : 1 = insert a bubble into E; M and W still advance.
//   rs_i/rt_i/a3_i   : D-stage source fields and destination (already 0 if no write).
//   wr_i, tnew_i     : D-stage write enable and Tnew at E entry.
//   *E_o/*M_o/*W_o   : current tracked state per stage.
module hazard_pipe_track
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned TNEW_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  a3_i,
  input  logic              wr_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [REG_W-1:0]  rsE_o,
  output logic [REG_W-1:0]  rtE_o,
  output logic [REG_W-1:0]  a3E_o,
  output logic              wrE_o,
  output logic [TNEW_W-1:0] tnewE_o,
  output logic [REG_W-1:0]  rtM_o,
  output logic [REG_W-1:0]  a3M_o,
  output logic              wrM_o,
  output logic [TNEW_W-1:0] tnewM_o,
  output logic [REG_W-1:0]  a3W_o,
  output logic              wrW_o
);

  logic [REG_W-1:0]  rsE_q, rsE_d, rtE_q, rtE_d, a3E_q, a3E_d;
  logic              wrE_q, wrE_d;
  logic [TNEW_W-1:0] tnewE_q, tnewE_d;
  logic [REG_W-1:0]  rtM_q, rtM_d, a3M_q, a3M_d;
  logic              wrM_q, wrM_d;
  logic [TNEW_W-1:0] tnewM_q, tnewM_d;
  logic [REG_W-1:0]  a3W_q, a3W_d;
  logic              wrW_q, wrW_d;

  always_comb begin
    if (stall_i) begin
      rsE_d   = '0;
      rtE_d   = '0;
      a3E_d   = '0;
      wrE_d   = 1'b0;
      tnewE_d = '0;
    end else begin
      rsE_d   = rs_i;
      rtE_d   = rt_i;
      a3E_d   = a3_i;
      wrE_d   = wr_i;
      tnewE_d = tnew_i;
    end
    rtM_d   = rtE_q;
    a3M_d   = a3E_q;
    wrM_d   = wrE_q;
    // One cycle of E elapses on the way to M; a ready result stays ready.
    tnewM_d = (tnewE_q == '0) ? '0 : tnewE_q - TNEW_W'(1);
    a3W_d   = a3M_q;
    wrW_d   = wrM_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsE_q   <= '0;
      rtE_q   <= '0;
      a3E_q   <= '0;
      wrE_q   <= 1'b0;
      tnewE_q <= '0;
      rtM_q   <= '0;
      a3M_q   <= '0;
      wrM_q   <= 1'b0;
      tnewM_q <= '0;
      a3W_q   <= '0;
      wrW_q   <= 1'b0;
    end else begin
      rsE_q   <= rsE_d;
      rtE_q   <= rtE_d;
      a3E_q   <= a3E_d;
      wrE_q   <= wrE_d;
      tnewE_q <= tnewE_d;
      rtM_q   <= rtM_d;
      a3M_q   <= a3M_d;
      wrM_q   <= wrM_d;
      tnewM_q <= tnewM_d;
      a3W_q   <= a3W_d;
      wrW_q   <= wrW_d;
    end
  end

  assign rsE_o   = rsE_q;
  assign rtE_o   = rtE_q;
  assign a3E_o   = a3E_q;
  assign wrE_o   = wrE_q;
  assign tnewE_o = tnewE_q;
  assign rtM_o   = rtM_q;
  assign a3M_o   = a3M_q;
  assign wrM_o   = wrM_q;
  assign tnewM_o = tnewM_q;
  assign a3W_o   = a3W_q;
  assign wrW_o   = wrW_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall and forwarding control for the 5-stage MIPS pipeline.
//   clk, reset            : clock, synchronous active-low reset.
//   cal_rD..jalD          : D-stage instruction class flags from the decoder.
//   rsD, rtD, a3D         : D-stage source fields and resolved destination.
//   RegWriteD             : D instruction writes the GPR file.
//   stall                 : hold PC and F/D, bubble into E.
//   ForwardRSD/RTD        : D compare/jr operand selects (GPR/W/M/E).
//   ForwardRSE/RTE        : E ALU operand selects (pipe/W/M).
//   ForwardRTM            : M store-data select (pipe/W).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned TNEW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cal_rD,
  input  logic             cal_iD,
  input  logic             ldD,
  input  logic             stD,
  input  logic             b_typeD,
  input  logic             jrD,
  input  logic             jalD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] a3D,
  input  logic             RegWriteD,
  output logic             stall,
  output logic [1:0]       ForwardRSD,
  output logic [1:0]       ForwardRTD,
  output logic [1:0]       ForwardRSE,
  output logic [1:0]       ForwardRTE,
  output logic             ForwardRTM
);

  logic [REG_W-1:0]  rsE, rtE, a3E, rtM, a3M, a3W, a3_in;
  logic              wrE, wrM, wrW;
  logic [TNEW_W-1:0] tnewE, tnewM, tnew_in, rs_tuse, rt_tuse;
  logic              rs_use, rt_use;
  logic              rs_hit_e, rs_hit_m, rs_hit_w, rt_hit_e, rt_hit_m, rt_hit_w;
  logic              rsE_hit_m, rsE_hit_w, rtE_hit_m, rtE_hit_w, rtM_hit_w;
  logic              rdy_e, rdy_m;

  function automatic logic hit(input logic [REG_W-1:0] src,
                               input logic [REG_W-1:0] a3,
                               input logic             wr);
    return wr && (a3 == src) && (a3 != REG_W'(REG_ZERO));
  endfunction

  // A nearer match whose result is not ready masks farther stages; the
  // stall logic holds the consumer until that match becomes forwardable.
  function automatic logic [1:0] fwd_d(input logic h_e, input logic r_e,
                                       input logic h_m, input logic r_m,
                                       input logic h_w);
    if (h_e)      return r_e ? FWD_E : FWD_GPR;
    else if (h_m) return r_m ? FWD_M : FWD_GPR;
    else if (h_w) return FWD_W;
    else          return FWD_GPR;
  endfunction

  function automatic logic [1:0] fwd_e(input logic h_m, input logic r_m,
                                       input logic h_w);
    if (h_m)      return r_m ? FWD_M : FWD_GPR;
    else if (h_w) return FWD_W;
    else          return FWD_GPR;
  endfunction

  always_comb begin
    rs_use  = b_typeD | jrD | cal_rD | cal_iD | ldD | stD;
    rs_tuse = (b_typeD | jrD) ? TNEW_W'(TUSE_0) : TNEW_W'(TUSE_1);
    rt_use  = b_typeD | cal_rD | stD;
    rt_tuse = b_typeD ? TNEW_W'(TUSE_0) :
              cal_rD  ? TNEW_W'(TUSE_1) : TNEW_W'(TUSE_2);

    if (cal_rD | cal_iD) tnew_in = TNEW_W'(TNEW_ALU);
    else if (ldD)        tnew_in = TNEW_W'(TNEW_LD);
    else if (jalD)       tnew_in = TNEW_W'(TNEW_0);
    else                 tnew_in = TNEW_W'(TNEW_0);

    a3_in = RegWriteD ? a3D : '0;
  end

  hazard_pipe_track #(
    .REG_W  (REG_W),
    .TNEW_W (TNEW_W)
  ) u_track (
    .clk_i   (clk),
    .rst_ni  (reset),
    .stall_i (stall),
    .rs_i    (rsD),
    .rt_i    (rtD),
    .a3_i    (a3_in),
    .wr_i    (RegWriteD),
    .tnew_i  (tnew_in),
    .rsE_o   (rsE),
    .rtE_o   (rtE),
    .a3E_o   (a3E),
    .wrE_o   (wrE),
    .tnewE_o (tnewE),
    .rtM_o   (rtM),
    .a3M_o   (a3M),
    .wrM_o   (wrM),
    .tnewM_o (tnewM),
    .a3W_o   (a3W),
    .wrW_o   (wrW)
  );

  always_comb begin
    rdy_e = (tnewE == '0);
    rdy_m = (tnewM == '0);

    rs_hit_e = rs_use && hit(rsD, a3E, wrE);
    rs_hit_m = rs_use && hit(rsD, a3M, wrM);
    rs_hit_w = rs_use && hit(rsD, a3W, wrW);
    rt_hit_e = rt_use && hit(rtD, a3E, wrE);
    rt_hit_m = rt_use && hit(rtD, a3M, wrM);
    rt_hit_w = rt_use && hit(rtD, a3W, wrW);

    rsE_hit_m = hit(rsE, a3M, wrM);
    rsE_hit_w = hit(rsE, a3W, wrW);
    rtE_hit_m = hit(rtE, a3M, wrM);
    rtE_hit_w = hit(rtE, a3W, wrW);
    rtM_hit_w = hit(rtM, a3W, wrW);

    stall = (rs_hit_e && (rs_tuse < tnewE)) || (rs_hit_m && (rs_tuse < tnewM)) ||
            (rt_hit_e && (rt_tuse < tnewE)) || (rt_hit_m && (rt_tuse < tnewM));

    ForwardRSD = fwd_d(rs_hit_e, rdy_e, rs_hit_m, rdy_m, rs_hit_w);
    ForwardRTD = fwd_d(rt_hit_e, rdy_e, rt_hit_m, rdy_m, rt_hit_w);
    ForwardRSE = fwd_e(rsE_hit_m, rdy_m, rsE_hit_w);
    ForwardRTE = fwd_e(rtE_hit_m, rdy_m, rtE_hit_w);
    ForwardRTM = rtM_hit_w ? FWD_M_W : FWD_M_PIPE;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed instruction sequences with hand-computed
// stall/forward expectations for hazard_unit.
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic       cal_rD, cal_iD, ldD, stD, b_typeD, jrD, jalD, RegWriteD;
  logic [4:0] rsD, rtD, a3D;
  logic       stall;
  logic [1:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;
  logic       ForwardRTM;

  int checks;
  int failures;

  hazard_unit #(
    .REG_W  (5),
    .TNEW_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cal_rD     (cal_rD),
    .cal_iD     (cal_iD),
    .ldD        (ldD),
    .stD        (stD),
    .b_typeD    (b_typeD),
    .jrD        (jrD),
    .jalD       (jalD),
    .rsD        (rsD),
    .rtD        (rtD),
    .a3D        (a3D),
    .RegWriteD  (RegWriteD),
    .stall      (stall),
    .ForwardRSD (ForwardRSD),
    .ForwardRTD (ForwardRTD),
    .ForwardRSE (ForwardRSE),
    .ForwardRTE (ForwardRTE),
    .ForwardRTM (ForwardRTM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic cr, input logic ci, input logic l, input logic s,
                       input logic b, input logic j, input logic jl,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] a3, input logic wr);
    cal_rD = cr; cal_iD = ci; ldD = l; stD = s; b_typeD = b; jrD = j; jalD = jl;
    rsD = rs; rtD = rt; a3D = a3; RegWriteD = wr;
  endtask

  task automatic i_nop;                                  set_d(0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0); endtask
  task automatic i_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
                                                         set_d(1,0,0,0,0,0,0, s, t, d, 1);          endtask
  task automatic i_ori(input logic [4:0] t, input logic [4:0] s);
                                                         set_d(0,1,0,0,0,0,0, s, t, t, 1);          endtask
  task automatic i_lw(input logic [4:0] t, input logic [4:0] base);
                                                         set_d(0,0,1,0,0,0,0, base, t, t, 1);       endtask
  task automatic i_sw(input logic [4:0] t, input logic [4:0] base);
                                                         set_d(0,0,0,1,0,0,0, base, t, 5'd0, 0);    endtask
  task automatic i_beq(input logic [4:0] s, input logic [4:0] t);
                                                         set_d(0,0,0,0,1,0,0, s, t, 5'd0, 0);       endtask
  task automatic i_jr(input logic [4:0] s, input logic [4:0] t);
                                                         set_d(0,0,0,0,0,1,0, s, t, 5'd0, 0);       endtask
  task automatic i_jal;                                  set_d(0,0,0,0,0,0,1, 5'd0, 5'd0, 5'd31, 1); endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic flush;
    i_nop;
    repeat (3) tick;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    i_nop;
    tick;
    tick;
    reset = 1'b1;

    // Reset state with idle D inputs
    sample;
    check("rst_stall", stall, 0);
    check("rst_RSD", ForwardRSD, 0);
    check("rst_RTD", ForwardRTD, 0);
    check("rst_RSE", ForwardRSE, 0);
    check("rst_RTE", ForwardRTE, 0);
    check("rst_RTM", ForwardRTM, 0);
    tick;

    // addu $3,$1,$2 ; subu $4,$3,$1 ; addu $9,$3,$0
    i_alu(5'd3, 5'd1, 5'd2);
    sample; check("t1_stall0", stall, 0);
    tick; i_alu(5'd4, 5'd3, 5'd1);
    sample; check("t1_stall1", stall, 0);
    tick; i_alu(5'd9, 5'd3, 5'd0);
    sample;
    check("t1_RSE_M", ForwardRSE, 2'b10);
    check("t1_RTE", ForwardRTE, 2'b00);
    check("t1_RSD_M", ForwardRSD, 2'b10);
    check("t1_stall2", stall, 0);
    tick; i_nop;
    sample; check("t1_RSE_W", ForwardRSE, 2'b01);
    flush;

    // lw $5,0($0) ; addu $6,$5,$5
    i_lw(5'd5, 5'd0);
    sample; check("t2_stall0", stall, 0);
    tick; i_alu(5'd6, 5'd5, 5'd5);
    sample; check("t2_stall1", stall, 1);
    tick;
    sample; check("t2_stall2", stall, 0);
    tick; i_nop;
    sample;
    check("t2_RSE_W", ForwardRSE, 2'b01);
    check("t2_RTE_W", ForwardRTE, 2'b01);
    flush;

    // lw $7 ; beq $7,$0
    i_lw(5'd7, 5'd0);
    tick; i_beq(5'd7, 5'd0);
    sample; check("t3_stall_a", stall, 1);
    tick;
    sample; check("t3_stall_b", stall, 1);
    tick;
    sample;
    check("t3_stall_c", stall, 0);
    check("t3_RSD_W", ForwardRSD, 2'b01);
    check("t3_RTD", ForwardRTD, 2'b00);
    flush;

    // jal ; jr $31 in the delay slot (rt field unrelated)
    i_jal;
    tick; i_jr(5'd31, 5'd5);
    sample;
    check("t4_stall", stall, 0);
    check("t4_RSD_E", ForwardRSD, 2'b11);
    check("t4_RTD", ForwardRTD, 2'b00);
    flush;

    // lw $8 ; sw $8,4($0)
    i_lw(5'd8, 5'd0);
    tick; i_sw(5'd8, 5'd0);
    sample; check("t5_stall", stall, 0);
    tick; i_nop;
    sample; check("t5_RTE_blocked", ForwardRTE, 2'b00);
    tick;
    sample; check("t5_RTM_W", ForwardRTM, 1);
    flush;

    // ori $0,$1,5 ; addu $2,$0,$0
    i_ori(5'd0, 5'd1);
    tick; i_alu(5'd2, 5'd0, 5'd0);
    sample;
    check("t6_stall", stall, 0);
    check("t6_RSD", ForwardRSD, 0);
    check("t6_RTD", ForwardRTD, 0);
    check("t6_RSE", ForwardRSE, 0);
    check("t6_RTE", ForwardRTE, 0);
    tick; i_nop;
    sample;
    check("t6_RSE_n", ForwardRSE, 0);
    check("t6_RTE_n", ForwardRTE, 0);
    check("t6_RTM", ForwardRTM, 0);
    flush;

    // lw $10 ; ori $10,$0 -- rt is a destination for ori, not an operand
    i_lw(5'd10, 5'd0);
    tick; i_ori(5'd10, 5'd0);
    sample; check("t7_rt_unused", stall, 0);
    flush;

    // Reset asserted during a load-use stall
    i_lw(5'd5, 5'd0);
    tick; i_alu(5'd6, 5'd5, 5'd5);
    sample; check("t8_stall_pre", stall, 1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    sample;
    check("t8_stall_post", stall, 0);
    check("t8_a3E", dut.u_track.a3E_o, 0);
    check("t8_a3M", dut.u_track.a3M_o, 0);
    check("t8_a3W", dut.u_track.a3W_o, 0);
    check("t8_RSD", ForwardRSD, 0);
    check("t8_RSE", ForwardRSE, 0);
    flush;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Sits directly downstream of the D-stage decoder and consumes its per-instruction class flags (cal_r, cal_i, ld, st, b_type, jr, jal), the rs/rt fields and the resolved write register.
- Carries its own copy of each instruction's destination and remaining result latency (Tnew) through E/M/W.
- Emits the D-stage stall/E-stage bubble and every forwarding-mux select in the datapath.

Parameters:
- REG_W, 5, register-index width.
- TNEW_W, 2, width of the Tnew counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state.
- cal_rD  in  1  D instr is R-type ALU (addu/subu).
- cal_iD  in  1  D instr is I-type ALU (ori/lui).
- ldD  in  1  D instr is a load (lw).
- stD  in  1  D instr is a store (sw).
- b_typeD  in  1  D instr is a branch (beq).
- jrD  in  1  D instr is jr.
- jalD  in  1  D instr is jal.
- rsD  in  REG_W  rs field of D instr.
- rtD  in  REG_W  rt field of D instr.
- a3D  in  REG_W  resolved destination register of D instr (rt/rd/31).
- RegWriteD  in  1  D instr writes the GPR.
- stall  out  1  1 = hold PC and F/D register; clear D/E register (bubble).
- ForwardRSD  out  2  D compare/jr operand rs: 00 GPR, 01 W result, 10 M ALU/PC+8, 11 E PC+8.
- ForwardRTD  out  2  D compare operand rt; same encoding as ForwardRSD.
- ForwardRSE  out  2  ALU A: 00 E pipe reg, 01 W result, 10 M ALU/PC+8.
- ForwardRTE  out  2  ALU B / store data in E; same encoding as ForwardRSE.
- ForwardRTM  out  1  DM write data: 0 M pipe reg, 1 W result.

Behaviour:
- Tuse (decode-time, combinational):
  - rs: 0 for b_type|jr; 1 for cal_r|cal_i|ld|st.
  - rt: 0 for b_type; 1 for cal_r; 2 for st.
  - Operand not used = no hazard.
- Tnew at E entry: cal_r|cal_i -> 1; ld -> 2; jal -> 0; else 0.
- Tracked state, all registered:
  - E: rsE, rtE, a3E, wrE, tnewE.
  - M: rtM, a3M, wrM, tnewM.
  - W: a3W, wrW.
  - Tnew is not kept for W; it is always 0 there.
- Advance each cycle with stall=0:
  - E <= D inputs (a3 forced to 0 when RegWriteD=0).
  - M <= E with tnewM = tnewE-1, saturating at 0.
  - W <= M.
- Advance with stall=1:
  - E <= bubble (all fields 0).
  - M and W still advance.
- Hazard match X=stage:
  - Requires a3X==src, a3X!=0 and wrX=1.
  - $0 never matches.
- stall = any D operand with a match in E and Tuse<tnewE, or a match in M and Tuse<tnewM.
- Forward priority is nearest stage first, and only from a source whose Tnew==0:
  - D operands: E (jal only) > M > W > GPR.
  - E operands: M > W > pipe reg.
  - rtM: W > pipe reg.
- A match with Tnew>0 in a nearer stage blocks forwarding from farther stages; stall covers that case.
- stall and all Forward* outputs are combinational from current state plus D inputs, valid in the same cycle.
- Reset:
  - All tracked state 0, so with zero D inputs stall=0 and Forward*=0.
  - Reset mid-stall drops the pending hazard; the next cycle starts clean.
- No flush: the branch delay slot always executes.

Decomposition:
- Shared package `hazard_pkg`:
  - FWD_* select encodings (00/01/10/11).
  - TUSE_*/TNEW_* constants.
  - REG_ZERO.
- One natural sub-module, `hazard_pipe_track`: the E/M/W tracking registers with the Tnew decrement and bubble insert.
- The top level does the Tuse decode, stall compare and forward priority.

Test Plan:
- addu $3,$1,$2 then subu $4,$3,$1 back-to-back -> stall=0; in subu's E cycle ForwardRSE=10; the cycle after, wrW for $3.
- lw $5,0($0) then addu $6,$5,$5 -> exactly 1 cycle stall=1; next cycle ForwardRSE=01 and ForwardRTE=01.
- lw $7 then beq $7,$0 -> stall=1 for 2 cycles; third cycle ForwardRSD=01, stall=0.
- jal (a3=31) then jr $31 in the delay slot -> stall=0, ForwardRSD=11; a non-matching rt gives ForwardRTD=00.
- lw $8 then sw $8,4($0) -> stall=0; in sw's M cycle ForwardRTM=1.
- ori $0,$1,5 then addu $2,$0,$0 -> no stall, all Forward*=00. Separately, reset=0 asserted during a lw-use stall -> next cycle stall=0 and all tracked a3=0.
